decode_vec_stage: RTL and testbench

- Parametrised decode stage for the vector filter CPU.
- Reads two vector operands (LANES x DW) from an internal register file with write-through bypass from writeback.
- Generates the lane-broadcast immediate and registers everything into an ID/EX pipeline register with stall, flush and operand patching while stalled.
- Sits between fetch (instr_d, pc_plus8_d) and execute; the writeback stage drives its write port.

---
 rtl/decode_vec_pkg.sv | 25 ++
 rtl/regfile_vec_bypass.sv | 59 +++++
 rtl/decode_vec_stage.sv | 146 ++++++++++++++
 tb/tb_decode_vec_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_vec_pkg.sv
// Shared types and constants for the vector decode stage.
// Default geometry matches the vector filter CPU.
package decode_vec_pkg;

   typedef enum logic [1:0] {
      IMM8     = 2'b00,
      IMM12    = 2'b01,
      BR24     = 2'b10,
      IMM_NONE = 2'b11
   } imm_src_t;

   localparam int LANES_DEF = 3;
   localparam int DW_DEF    = 18;
   localparam int NREGS_DEF = 16;

   // The highest register index aliases the PC.
   function automatic int pc_reg(input int nregs);
      return nregs - 1;
   endfunction

   localparam int PC_REG = pc_reg(NREGS_DEF);

   typedef logic [LANES_DEF*DW_DEF-1:0] lane_vec_t;

endpackage

// File: rtl/regfile_vec_bypass.sv
// Vector register file: one write port, two combinational read ports with
// write-through bypass, and the top index aliased to PC+8 on every lane.
module regfile_vec_bypass
   import decode_vec_pkg::*;
#(
   parameter int LANES = 3,
   parameter int DW    = 18,
   parameter int NREGS = 16,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we_i,
   input  logic [AW-1:0]         wa_i,
   input  logic [LANES*DW-1:0]   wd_i,
   input  logic [AW-1:0]         ra1_i,
   input  logic [AW-1:0]         ra2_i,
   input  logic [DW-1:0]         pc_i,
   output logic [LANES*DW-1:0]   rd1_o,
   output logic [LANES*DW-1:0]   rd2_o
);

   localparam logic [AW-1:0] PC_ADDR = AW'(pc_reg(NREGS));

   logic [LANES*DW-1:0] mem_q [NREGS];
   logic                wr_en;

   assign wr_en = we_i && (wa_i != PC_ADDR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wa_i] <= wd_i;
      end
   end

   // A write in flight is visible to the same-cycle read.
   always_comb begin
      rd1_o = mem_q[ra1_i];
      if (ra1_i == PC_ADDR) begin
         rd1_o = {LANES{pc_i}};
      end else if (wr_en && (wa_i == ra1_i)) begin
         rd1_o = wd_i;
      end
   end

   always_comb begin
      rd2_o = mem_q[ra2_i];
      if (ra2_i == PC_ADDR) begin
         rd2_o = {LANES{pc_i}};
      end else if (wr_en && (wa_i == ra2_i)) begin
         rd2_o = wd_i;
      end
   end

endmodule

// File: rtl/decode_vec_stage.sv
// Vector decode stage: operand read, lane-broadcast immediate and the ID/EX
// register with stall, flush and writeback patching of held operands.
module decode_vec_stage
   import decode_vec_pkg::*;
#(
   parameter int LANES = 3,
   parameter int DW    = 18,
   parameter int NREGS = 16,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           instr_d,
   input  logic [DW-1:0]         pc_plus8_d,
   input  logic [1:0]            reg_src_d,
   input  logic [1:0]            imm_src_d,
   input  logic                  valid_d,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  we_w,
   input  logic [AW-1:0]         wa_w,
   input  logic [LANES*DW-1:0]   wd_w,
   output logic                  ex_valid,
   output logic [LANES*DW-1:0]   ex_rd1,
   output logic [LANES*DW-1:0]   ex_rd2,
   output logic [LANES*DW-1:0]   ex_imm,
   output logic [AW-1:0]         ex_ra1,
   output logic [AW-1:0]         ex_ra2,
   output logic [AW-1:0]         ex_wa
);

   localparam logic [AW-1:0] PC_ADDR = AW'(pc_reg(NREGS));

   logic [AW-1:0]        ra1, ra2, wa;
   logic [LANES*DW-1:0]  rd1, rd2;
   logic [31:0]          imm32;
   logic [DW-1:0]        imm_lane;
   logic                 unused_instr;

   assign ra1 = reg_src_d[0] ? PC_ADDR : AW'(instr_d[19:16]);
   assign ra2 = reg_src_d[1] ? AW'(instr_d[15:12]) : AW'(instr_d[3:0]);
   assign wa  = AW'(instr_d[15:12]);
   assign unused_instr = ^instr_d[31:24];

   regfile_vec_bypass #(
      .LANES (LANES),
      .DW    (DW),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (we_w),
      .wa_i  (wa_w),
      .wd_i  (wd_w),
      .ra1_i (ra1),
      .ra2_i (ra2),
      .pc_i  (pc_plus8_d),
      .rd1_o (rd1),
      .rd2_o (rd2)
   );

   always_comb begin
      imm32 = '0;
      unique case (imm_src_t'(imm_src_d))
         IMM8:    imm32 = {24'b0, instr_d[7:0]};
         IMM12:   imm32 = {20'b0, instr_d[11:0]};
         BR24:    imm32 = {{6{instr_d[23]}}, instr_d[23:0], 2'b00};
         default: imm32 = '0;
      endcase
   end

   assign imm_lane = imm32[DW-1:0];

   logic                 ex_valid_q, ex_valid_d;
   logic [LANES*DW-1:0]  ex_rd1_q, ex_rd1_d;
   logic [LANES*DW-1:0]  ex_rd2_q, ex_rd2_d;
   logic [LANES*DW-1:0]  ex_imm_q, ex_imm_d;
   logic [AW-1:0]        ex_ra1_q, ex_ra1_d;
   logic [AW-1:0]        ex_ra2_q, ex_ra2_d;
   logic [AW-1:0]        ex_wa_q, ex_wa_d;
   logic                 patch1, patch2;

   // While stalled, a writeback to a held source keeps that operand current.
   assign patch1 = we_w && (wa_w != PC_ADDR) && (wa_w == ex_ra1_q);
   assign patch2 = we_w && (wa_w != PC_ADDR) && (wa_w == ex_ra2_q);

   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_rd1_d   = ex_rd1_q;
      ex_rd2_d   = ex_rd2_q;
      ex_imm_d   = ex_imm_q;
      ex_ra1_d   = ex_ra1_q;
      ex_ra2_d   = ex_ra2_q;
      ex_wa_d    = ex_wa_q;
      if (flush) begin
         ex_valid_d = 1'b0;
         ex_rd1_d   = '0;
         ex_rd2_d   = '0;
         ex_imm_d   = '0;
         ex_ra1_d   = '0;
         ex_ra2_d   = '0;
         ex_wa_d    = '0;
      end else if (stall) begin
         if (patch1) ex_rd1_d = wd_w;
         if (patch2) ex_rd2_d = wd_w;
      end else begin
         ex_valid_d = valid_d;
         ex_rd1_d   = rd1;
         ex_rd2_d   = rd2;
         ex_imm_d   = {LANES{imm_lane}};
         ex_ra1_d   = ra1;
         ex_ra2_d   = ra2;
         ex_wa_d    = wa;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         ex_rd1_q   <= '0;
         ex_rd2_q   <= '0;
         ex_imm_q   <= '0;
         ex_ra1_q   <= '0;
         ex_ra2_q   <= '0;
         ex_wa_q    <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_rd1_q   <= ex_rd1_d;
         ex_rd2_q   <= ex_rd2_d;
         ex_imm_q   <= ex_imm_d;
         ex_ra1_q   <= ex_ra1_d;
         ex_ra2_q   <= ex_ra2_d;
         ex_wa_q    <= ex_wa_d;
      end
   end

   assign ex_valid = ex_valid_q;
   assign ex_rd1   = ex_rd1_q;
   assign ex_rd2   = ex_rd2_q;
   assign ex_imm   = ex_imm_q;
   assign ex_ra1   = ex_ra1_q;
   assign ex_ra2   = ex_ra2_q;
   assign ex_wa    = ex_wa_q;

endmodule

// File: tb/tb_decode_vec_stage.sv
// Bench for decode_vec_stage: directed scenarios then random traffic, with a
// reference model feeding an expected queue drained by an output monitor.
module tb_decode_vec_stage;

   localparam int LANES = 3;
   localparam int DW    = 18;
   localparam int NREGS = 16;
   localparam int AW    = 4;
   localparam int VW    = LANES * DW;

   typedef logic [VW-1:0] vec_t;
   typedef struct packed {
      logic          v;
      vec_t          rd1;
      vec_t          rd2;
      vec_t          imm;
      logic [AW-1:0] ra1;
      logic [AW-1:0] ra2;
      logic [AW-1:0] wa;
   } ex_t;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [31:0]   instr_d;
   logic [DW-1:0] pc_plus8_d;
   logic [1:0]    reg_src_d;
   logic [1:0]    imm_src_d;
   logic          valid_d;
   logic          stall;
   logic          flush;
   logic          we_w;
   logic [AW-1:0] wa_w;
   vec_t          wd_w;
   logic          ex_valid;
   vec_t          ex_rd1, ex_rd2, ex_imm;
   logic [AW-1:0] ex_ra1, ex_ra2, ex_wa;

   decode_vec_stage #(.LANES(LANES), .DW(DW), .NREGS(NREGS), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr_d    (instr_d),
      .pc_plus8_d (pc_plus8_d),
      .reg_src_d  (reg_src_d),
      .imm_src_d  (imm_src_d),
      .valid_d    (valid_d),
      .stall      (stall),
      .flush      (flush),
      .we_w       (we_w),
      .wa_w       (wa_w),
      .wd_w       (wd_w),
      .ex_valid   (ex_valid),
      .ex_rd1     (ex_rd1),
      .ex_rd2     (ex_rd2),
      .ex_imm     (ex_imm),
      .ex_ra1     (ex_ra1),
      .ex_ra2     (ex_ra2),
      .ex_wa      (ex_wa)
   );

   int tests  = 0;
   int failed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model
   vec_t mdl [NREGS];
   ex_t  m_ex;
   ex_t  exp_q [$];

   function automatic vec_t m_read(input int ra);
      if (ra == NREGS - 1) return {LANES{pc_plus8_d}};
      if (we_w && int'(wa_w) == ra && int'(wa_w) != NREGS - 1) return wd_w;
      return mdl[ra];
   endfunction

   function automatic logic [DW-1:0] m_imm(input logic [31:0] ins, input logic [1:0] src);
      longint v;
      case (src)
         2'd0: v = longint'(ins) & 64'hFF;
         2'd1: v = longint'(ins) & 64'hFFF;
         2'd2: begin
            v = longint'(ins) & 64'hFF_FFFF;
            if (v >= 64'h80_0000) v = v - 64'h100_0000;
            v = v * 4;
         end
         default: v = 0;
      endcase
      return DW'(v);
   endfunction

   initial begin
      int a1, a2;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mdl[i] = '0;
            m_ex = '0;
         end else begin
            a1 = reg_src_d[0] ? NREGS - 1 : int'(instr_d[19:16]);
            a2 = reg_src_d[1] ? int'(instr_d[15:12]) : int'(instr_d[3:0]);
            if (flush) begin
               m_ex = '0;
            end else if (stall) begin
               if (we_w && int'(wa_w) != NREGS - 1 && wa_w == m_ex.ra1) m_ex.rd1 = wd_w;
               if (we_w && int'(wa_w) != NREGS - 1 && wa_w == m_ex.ra2) m_ex.rd2 = wd_w;
            end else begin
               m_ex.v   = valid_d;
               m_ex.rd1 = m_read(a1);
               m_ex.rd2 = m_read(a2);
               m_ex.imm = {LANES{m_imm(instr_d, imm_src_d)}};
               m_ex.ra1 = AW'(a1);
               m_ex.ra2 = AW'(a2);
               m_ex.wa  = instr_d[15:12];
            end
            if (we_w && int'(wa_w) != NREGS - 1) mdl[wa_w] = wd_w;
         end
         exp_q.push_back(m_ex);
      end
   end

   // monitor
   initial begin
      ex_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ex_valid", 64'(ex_valid), 64'(e.v));
            chk("ex_rd1",   64'(ex_rd1),   64'(e.rd1));
            chk("ex_rd2",   64'(ex_rd2),   64'(e.rd2));
            chk("ex_imm",   64'(ex_imm),   64'(e.imm));
            chk("ex_ra1",   64'(ex_ra1),   64'(e.ra1));
            chk("ex_ra2",   64'(ex_ra2),   64'(e.ra2));
            chk("ex_wa",    64'(ex_wa),    64'(e.wa));
         end
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      instr_d    = '0;
      pc_plus8_d = '0;
      reg_src_d  = '0;
      imm_src_d  = 2'd3;
      valid_d    = 1'b0;
      stall      = 1'b0;
      flush      = 1'b0;
      we_w       = 1'b0;
      wa_w       = '0;
      wd_w       = '0;
   endtask

   vec_t k_vec;

   initial begin
      rst_n = 1'b0;
      idle();
      cyc();
      cyc();
      rst_n = 1'b1;

      for (int r = 0; r < NREGS - 1; r++) begin
         we_w = 1'b1;
         wa_w = AW'(r);
         wd_w = {$urandom, $urandom};
         cyc();
      end
      idle();

      rst_n = 1'b0;
      cyc();
      cyc();
      chk("reset_valid", 64'(ex_valid), 64'd0);
      chk("reset_rd1", 64'(ex_rd1), 64'd0);
      rst_n = 1'b1;

      instr_d = 32'h0003_0000;
      valid_d = 1'b1;
      cyc();
      chk("r3_after_reset", 64'(ex_rd1), 64'd0);

      we_w = 1'b1;
      wa_w = 4'd5;
      k_vec = {18'h1, 18'h2, 18'h3};
      wd_w = k_vec;
      instr_d = 32'h0005_0000;
      cyc();
      chk("bypass_rd1", 64'(ex_rd1), 64'(k_vec));
      chk("bypass_valid", 64'(ex_valid), 64'd1);

      reg_src_d  = 2'b01;
      pc_plus8_d = 18'h0108;
      wa_w       = 4'd15;
      wd_w       = {LANES{18'h3FFFF}};
      cyc();
      k_vec = {LANES{18'h0108}};
      chk("pc_alias", 64'(ex_rd1), 64'(k_vec));
      we_w = 1'b0;
      cyc();
      chk("pc_alias_again", 64'(ex_rd1), 64'(k_vec));

      reg_src_d = 2'b00;
      imm_src_d = 2'd2;
      instr_d   = 32'h00FF_FFFE;
      cyc();
      k_vec = {LANES{18'h3FFF8}};
      chk("imm_br24", 64'(ex_imm), 64'(k_vec));
      imm_src_d = 2'd0;
      instr_d   = 32'h0000_00A5;
      cyc();
      k_vec = {LANES{18'h000A5}};
      chk("imm8", 64'(ex_imm), 64'(k_vec));

      instr_d = 32'h0000_0007;
      cyc();
      stall   = 1'b1;
      instr_d = 32'h0001_2003;
      we_w    = 1'b1;
      wa_w    = 4'd7;
      wd_w    = {LANES{18'h00ABC}};
      cyc();
      k_vec = {LANES{18'h00ABC}};
      chk("stall_patch", 64'(ex_rd2), 64'(k_vec));
      chk("stall_ra2", 64'(ex_ra2), 64'd7);
      chk("stall_valid", 64'(ex_valid), 64'd1);
      we_w  = 1'b0;
      flush = 1'b1;
      cyc();
      chk("flush_valid", 64'(ex_valid), 64'd0);
      chk("flush_rd2", 64'(ex_rd2), 64'd0);
      stall = 1'b0;
      flush = 1'b0;
      cyc();
      chk("after_flush_valid", 64'(ex_valid), 64'd1);

      for (int n = 0; n < 500; n++) begin
         rst_n      = ($urandom_range(0, 99) >= 2);
         instr_d    = $urandom;
         pc_plus8_d = DW'($urandom);
         reg_src_d  = 2'($urandom_range(0, 3));
         imm_src_d  = 2'($urandom_range(0, 3));
         valid_d    = 1'($urandom_range(0, 1));
         stall      = ($urandom_range(0, 99) < 30);
         flush      = ($urandom_range(0, 99) < 10);
         we_w       = 1'($urandom_range(0, 1));
         wa_w       = AW'($urandom_range(0, NREGS - 1));
         wd_w       = {$urandom, $urandom};
         cyc();
      end

      rst_n = 1'b1;
      idle();
      cyc();
      cyc();
      @(negedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
